// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for EX-stage DIV/DIVU requests.
// Produces {remainder, quotient} after WIDTH iteration cycles; divide-by-zero completes immediately.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_en,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result_div
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             start_c;
    logic             div0_c;
    logic             last_c;
    logic             op1_neg_c;
    logic             op2_neg_c;
    logic [WIDTH-1:0] op1_mag_c;
    logic [WIDTH-1:0] op2_mag_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] rem_step_c;
    logic [WIDTH-1:0] quo_step_c;
    logic [WIDTH-1:0] rem_fix_c;
    logic [WIDTH-1:0] quo_fix_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; cancel overrides any transition and suppresses start/finish
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        div0_c     = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (div_en) begin
                    start_c = 1'b1;
                    if (operand_2 == '0) begin
                        div0_c     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (count == CW'(WIDTH - 1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) begin
            state_next = IDLE;
            start_c    = 1'b0;
            div0_c     = 1'b0;
            last_c     = 1'b0;
        end
    end

    // Operand magnitudes and one restoring step
    always_comb begin
        op1_neg_c  = signed_div & operand_1[WIDTH-1];
        op2_neg_c  = signed_div & operand_2[WIDTH-1];
        op1_mag_c  = op1_neg_c ? -operand_1 : operand_1;
        op2_mag_c  = op2_neg_c ? -operand_2 : operand_2;
        shifted_c  = {rem, quo[WIDTH-1]};
        diff_c     = shifted_c - {1'b0, dvs};
        quo_step_c = {quo[WIDTH-2:0], ~diff_c[WIDTH]};
        rem_step_c = diff_c[WIDTH] ? shifted_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
        quo_fix_c  = neg_q ? -quo_step_c : quo_step_c;
        rem_fix_c  = neg_r ? -rem_step_c : rem_step_c;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_div <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            if (start_c) begin
                count <= '0;
                rem   <= '0;
                quo   <= op1_mag_c;
                dvs   <= op2_mag_c;
                neg_q <= op1_neg_c ^ op2_neg_c;
                neg_r <= op1_neg_c;
            end
            if (div0_c) begin
                result_div <= {operand_1, {WIDTH{1'b1}}};
            end
            if (state == CALC) begin
                rem   <= rem_step_c;
                quo   <= quo_step_c;
                count <= count + CW'(1);
            end
            if (last_c) begin
                result_div <= {rem_fix_c, quo_fix_c};
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model feeding a scoreboard
// checked by an independent monitor on every done pulse.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           div_en;
    logic           signed_div;
    logic [W-1:0]   operand_1;
    logic [W-1:0]   operand_2;
    logic           cancel;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result_div;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_exp  = '0;
    logic        prev_done = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_en     (div_en),
        .signed_div (signed_div),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .result_div (result_div)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero for the signed case
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb_v;
        logic signed [63:0] q;
        logic signed [63:0] r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        sa   = 64'($signed(a));
        sb_v = 64'($signed(b));
        q    = sa / sb_v;
        r    = sa % sb_v;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_single_pulse", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %h at cycle %0d, none expected", result_div, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_div", result_div, e.res);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                last_exp = e.res;
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        operand_1  = a;
        operand_2  = b;
        signed_div = s;
        div_en     = 1'b1;
        e.res      = model(a, b, s);
        e.cyc      = cyc + ((b == 0) ? 1 : 33);
        sb.push_back(e);
    endtask

    // Waits for done, checking busy each cycle; returns just after the next rising edge
    task automatic wait_done(input bit scramble);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("busy", 64'(busy), 64'(k >= 1));
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (scramble && k == 3) begin
                operand_1  = $urandom;
                operand_2  = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        div_en = 1'b0;
        cancel = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s);
        issue(a, b, s);
        wait_done(1'b0);
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          sel;

        rst        = 1'b1;
        div_en     = 1'b0;
        cancel     = 1'b0;
        signed_div = 1'b0;
        operand_1  = '0;
        operand_2  = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result_div, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Directed cases
        run(32'd100, 32'd7, 1'b0);
        run(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        run(32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run(32'h1234_5678, 32'h0000_0000, 1'b0);
        run(32'h8765_4321, 32'h0000_0000, 1'b1);

        // Back-to-back with div_en held high
        issue(32'd100, 32'd7, 1'b0);
        wait_done(1'b0);
        issue(32'd9, 32'd3, 1'b0);
        wait_done(1'b0);
        idle(2);

        // cancel and div_en together in IDLE: no start
        div_en    = 1'b1;
        cancel    = 1'b1;
        operand_1 = 32'd50;
        operand_2 = 32'd5;
        @(posedge clk);
        #1;
        div_en = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // cancel in cycle 10 of a division
        operand_1  = 32'd1000;
        operand_2  = 32'd3;
        signed_div = 1'b0;
        div_en     = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        div_en = 1'b0;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_result_hold", result_div, last_exp);
        idle(40);

        // rst in cycle 20 of a division
        operand_1 = 32'hDEAD_BEEF;
        operand_2 = 32'd17;
        div_en    = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rst    = 1'b1;
        div_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result_div, 64'd0);
        last_exp = '0;
        @(posedge clk);
        #1;
        run(32'd100, 32'd7, 1'b0);

        // Randomized requests, mixed idle gaps and back-to-back, operands disturbed mid-run
        for (int i = 0; i < 60; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            s = 1'($urandom_range(0, 1));
            issue(a, b, s);
            wait_done(1'b1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
